// File: rtl/commit_trace_fifo.sv
// Commit-trace FIFO: compacts up to N_CH commits/cycle into a ring and drains one per cycle; 1-cycle min latency, no bypass.
// Backpressure: in_ready from registered level only (room for a full lane group); commits offered while not ready are dropped and flagged.
module commit_trace_fifo #(
    parameter int N_CH   = 2,
    parameter int DEPTH  = 16,
    parameter int PC_W   = 64,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 64,
    localparam int LANE_W = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int LVL_W  = PTR_W + 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_CH-1:0]          in_commit,
    input  logic [N_CH*PC_W-1:0]     in_pc,
    input  logic [N_CH*5-1:0]        in_reg_num,
    input  logic [N_CH*DATA_W-1:0]   in_wdata,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [4:0]               out_reg_num,
    output logic [DATA_W-1:0]        out_wdata,
    output logic [LANE_W-1:0]        out_lane,
    output logic [LVL_W-1:0]         level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         commit_count
);

    localparam logic [LVL_W-1:0] READY_MAX = LVL_W'(DEPTH - N_CH);

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [4:0]        reg_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [LANE_W-1:0] lane_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] k;
    logic [PTR_W-1:0] off [N_CH];
    logic             any_commit;
    logic             accept;
    logic             deq;

    assign in_ready   = (level <= READY_MAX);
    assign out_valid  = (level != '0);
    assign any_commit = (in_commit != '0);
    assign accept     = in_ready && any_commit;
    assign deq        = out_valid && out_ready;

    // Each active lane's slot offset is the number of active lanes below it.
    always_comb begin
        k = '0;
        for (int i = 0; i < N_CH; i++) begin
            off[i] = k;
            if (in_commit[i]) begin
                k = k + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            overflow     <= 1'b0;
            commit_count <= '0;
        end else begin
            if (accept) begin
                wr_ptr       <= wr_ptr + k;
                commit_count <= commit_count + CNT_W'(k);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level + (accept ? {1'b0, k} : LVL_W'(0)) - (deq ? LVL_W'(1) : LVL_W'(0));
            if (!in_ready && any_commit) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            for (int i = 0; i < N_CH; i++) begin
                if (in_commit[i]) begin
                    pc_mem[wr_ptr + off[i]]   <= in_pc[i*PC_W +: PC_W];
                    reg_mem[wr_ptr + off[i]]  <= in_reg_num[i*5 +: 5];
                    data_mem[wr_ptr + off[i]] <= in_wdata[i*DATA_W +: DATA_W];
                    lane_mem[wr_ptr + off[i]] <= LANE_W'(i);
                end
            end
        end
    end

    assign out_pc      = pc_mem[rd_ptr];
    assign out_reg_num = reg_mem[rd_ptr];
    assign out_wdata   = data_mem[rd_ptr];
    assign out_lane    = lane_mem[rd_ptr];

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Directed bench for commit_trace_fifo with N_CH=2, DEPTH=16.
module tb_commit_trace_fifo;

    logic          clock = 1'b0;
    logic          reset;
    logic [1:0]    in_commit;
    logic [127:0]  in_pc;
    logic [9:0]    in_reg_num;
    logic [127:0]  in_wdata;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_pc;
    logic [4:0]    out_reg_num;
    logic [63:0]   out_wdata;
    logic [0:0]    out_lane;
    logic [4:0]    level;
    logic          overflow;
    logic [63:0]   commit_count;

    int n_chk  = 0;
    int n_pass = 0;

    commit_trace_fifo dut (
        .clock        (clock),
        .reset        (reset),
        .in_commit    (in_commit),
        .in_pc        (in_pc),
        .in_reg_num   (in_reg_num),
        .in_wdata     (in_wdata),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_reg_num  (out_reg_num),
        .out_wdata    (out_wdata),
        .out_lane     (out_lane),
        .level        (level),
        .overflow     (overflow),
        .commit_count (commit_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] c,
                         input logic [63:0] p0, input logic [4:0] r0, input logic [63:0] d0,
                         input logic [63:0] p1, input logic [4:0] r1, input logic [63:0] d1);
        in_commit  = c;
        in_pc      = {p1, p0};
        in_reg_num = {r1, r0};
        in_wdata   = {d1, d0};
    endtask

    task automatic idle();
        drive(2'b00, 64'h0, 5'd0, 64'h0, 64'h0, 5'd0, 64'h0);
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b0;
        idle();
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_count", commit_count, 64'd0);
        tick();
        reset = 1'b0;
        tick();

        // Single lane-0 commit
        drive(2'b01, 64'h8000_0000, 5'd5, 64'h11, 64'h0, 5'd0, 64'h0);
        tick();
        idle();
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_pc", out_pc, 64'h8000_0000);
        chk("t1_reg", 64'(out_reg_num), 64'd5);
        chk("t1_wdata", out_wdata, 64'h11);
        chk("t1_lane", 64'(out_lane), 64'd0);
        chk("t1_count", commit_count, 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t1_drained", 64'(out_valid), 64'd0);

        // Compaction: lane1 alone, then both lanes
        drive(2'b10, 64'h0, 5'd0, 64'h0, 64'hA000, 5'd7, 64'hAA);
        tick();
        drive(2'b11, 64'hB000, 5'd8, 64'hBB, 64'hC000, 5'd0, 64'hCC);
        tick();
        idle();
        chk("t2_level", 64'(level), 64'd3);
        chk("t2_count", commit_count, 64'd4);
        chk("t2_a_pc", out_pc, 64'hA000);
        chk("t2_a_lane", 64'(out_lane), 64'd1);
        chk("t2_a_wdata", out_wdata, 64'hAA);
        out_ready = 1'b1;
        tick();
        chk("t2_b_pc", out_pc, 64'hB000);
        chk("t2_b_lane", 64'(out_lane), 64'd0);
        chk("t2_b_reg", 64'(out_reg_num), 64'd8);
        tick();
        chk("t2_c_pc", out_pc, 64'hC000);
        chk("t2_c_lane", 64'(out_lane), 64'd1);
        chk("t2_c_reg0", 64'(out_reg_num), 64'd0);
        tick();
        out_ready = 1'b0;
        chk("t2_empty", 64'(level), 64'd0);

        // Fill to DEPTH with full lane groups
        for (int c = 0; c < 8; c++) begin
            chk("t3_ready_fill", 64'(in_ready), 64'd1);
            drive(2'b11, 64'h100 + 64'(2*c), 5'd1, 64'(c), 64'h101 + 64'(2*c), 5'd2, 64'(c));
            tick();
        end
        idle();
        chk("t3_level16", 64'(level), 64'd16);
        chk("t3_ready16", 64'(in_ready), 64'd0);
        chk("t3_overflow", 64'(overflow), 64'd0);
        chk("t3_count", commit_count, 64'd20);
        chk("t3_head_stable", out_pc, 64'h100);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t3_level15", 64'(level), 64'd15);
        chk("t3_ready15", 64'(in_ready), 64'd0);

        // Drop while not ready
        drive(2'b01, 64'hDEAD, 5'd3, 64'hDEAD, 64'h0, 5'd0, 64'h0);
        tick();
        idle();
        chk("t4_level", 64'(level), 64'd15);
        chk("t4_overflow", 64'(overflow), 64'd1);
        chk("t4_count", commit_count, 64'd20);
        out_ready = 1'b1;
        for (int j = 0; j < 15; j++) begin
            chk("t4_drain_pc", out_pc, 64'h101 + 64'(j));
            tick();
        end
        out_ready = 1'b0;
        chk("t4_empty", 64'(level), 64'd0);
        chk("t4_overflow_sticky", 64'(overflow), 64'd1);

        // Streaming with simultaneous enqueue/dequeue across pointer wraps
        out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) begin
                chk("t5_level", 64'(level), 64'd1);
                chk("t5_pc", out_pc, 64'h5000 + 64'(c - 1));
            end
            drive(2'b01, 64'h5000 + 64'(c), 5'd9, 64'(c), 64'h0, 5'd0, 64'h0);
            tick();
        end
        idle();
        out_ready = 1'b0;
        chk("t5_level_end", 64'(level), 64'd1);
        chk("t5_count", commit_count, 64'd60);
        chk("t5_last_pc", out_pc, 64'h5027);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t5_empty", 64'(level), 64'd0);

        // Async reset with occupancy 7
        for (int c = 0; c < 3; c++) begin
            drive(2'b11, 64'h7000, 5'd1, 64'h1, 64'h7001, 5'd2, 64'h2);
            tick();
        end
        drive(2'b01, 64'h7100, 5'd1, 64'h1, 64'h0, 5'd0, 64'h0);
        tick();
        idle();
        chk("t6_level7", 64'(level), 64'd7);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_valid", 64'(out_valid), 64'd0);
        chk("t6_async_level", 64'(level), 64'd0);
        chk("t6_async_ready", 64'(in_ready), 64'd1);
        chk("t6_async_overflow", 64'(overflow), 64'd0);
        chk("t6_async_count", commit_count, 64'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("t6_post_valid", 64'(out_valid), 64'd0);
        chk("t6_post_level", 64'(level), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
